beat_control_unit: RTL and testbench
====================================

// Module: beat_control_unit
// PURPOSE
//   Hardwired control unit for the multicycle CPU. It consumes the one-hot beat vector t[3:0] (T1..T4) from the four-beat generator.
//   It holds PC, IR, halt state and latched ALU flags.
//   Each instruction runs over one beat round: T1 fetch, T2 decode/PC++, T3 execute, T4 writeback.
//   Drives memory, ALU and register-file strobes for the datapath.
// PARAMETERS
//   PC_W      8       PC / memory address width
//   IR_W      16      instruction width
//   RESET_PC  8'h00   PC value after reset
// PORTS
//   clk        in   1      system clock (same clock as the beat generator)
//   rst        in   1      asynchronous, active-high reset
//   t          in   4      one-hot beat vector: 0001=T1, 0010=T2, 0100=T3, 1000=T4
//   instr_in   in   IR_W   instruction word from memory (valid during T1)
//   alu_z      in   1      ALU zero result (valid during T3)
//   alu_c      in   1      ALU carry result (valid during T3)
//   pc         out  PC_W   program counter
//   ir         out  IR_W   instruction register
//   mem_addr   out  PC_W   T1: pc; T3: ir[7:0]
//   mem_rd     out  1      memory read strobe
//   mem_wr     out  1      memory write strobe
//   alu_op     out  3      0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 PASS_B
//   alu_en     out  1      ALU operand/result latch enable
//   rd_sel     out  3      destination register = ir[10:8]
//   rs_sel     out  3      source register = ir[2:0]
//   wb_sel     out  2      0 ALU result, 1 immediate ir[7:0], 2 memory data
//   reg_we     out  1      register-file write enable
//   halted     out  1      HALT executed; sticky until rst
//   illegal_op out  1      one-cycle pulse in T2 for an undefined opcode
//   beat_err   out  1      sticky: t seen not one-hot and not 0000
// BEHAVIOUR
//   Opcode = ir[15:12]:
//     0 NOP, 1 ADD, 2 SUB, 3 AND, 4 OR, 5 XOR, 6 MOV, 7 MVI, 8 LDA, 9 STA, A JMP, B JZ, C JC, F HALT.
//     Opcodes D and E are illegal; they execute as NOP.
//   Registered state: pc, ir, halted, z_q, c_q, beat_err.
//   All strobes are combinational from (t, ir, halted), so there is zero latency to the beat.
//   Reset (async): pc=RESET_PC, ir=0 (NOP), halted=0, z_q=c_q=0, beat_err=0.
//     Every strobe is therefore 0 while rst is high and while t==0000.
//   T1: mem_addr=pc, mem_rd=1. On the clk edge: ir<=instr_in.
//   T2: on the clk edge, pc<=pc+1, wrapping 8'hFF->8'h00.
//       illegal_op=1 for this cycle when the opcode is D or E.
//   T3:
//     - ALU ops (1-5) and MOV: alu_en=1, alu_op per opcode (MOV uses PASS_B).
//       For opcodes 1-5 only, z_q<=alu_z and c_q<=alu_c on the edge.
//     - LDA: mem_addr=ir[7:0], mem_rd=1.
//     - STA: mem_addr=ir[7:0], mem_wr=1; rd_sel names the source register.
//     - JMP: pc<=ir[7:0].
//     - JZ/JC: pc<=ir[7:0] only when z_q / c_q is 1.
//     - HALT: halted<=1.
//   T4: reg_we=1 for ALU ops, MOV (wb_sel=0), MVI (wb_sel=1) and LDA (wb_sel=2). No other strobes.
//   Branch at T3 overrides the T2 increment; the target is exact, with no +1.
//   halted=1: pc, ir, flags frozen; all strobes 0 for every beat; only rst clears.
//   t==0000: idle, no state change.
//   t not one-hot and not 0000: treated as idle; beat_err<=1 (sticky).
//   Reset mid-instruction: the instruction is abandoned.
//     No strobe may assert until the next T1 fetch from RESET_PC.
// STRUCTURE
//   Shared package cpu_defs_pkg:
//     - opcode localparams (OP_NOP..OP_HALT)
//     - beat constants T1=4'b0001 .. T4=4'b1000
//     - ALU_* op codes and WB_* select codes
//   One combinational sub-module, instr_decoder (ir -> op class, alu_op, wb_sel, illegal).
//   The sequential part stays in beat_control_unit.
// TESTING
//   - rst pulse mid-T3 of STA -> mem_wr drops immediately; pc=00, ir=0000; next T1 fetches addr 00.
//   - MVI r3,#5A at addr 00 -> T1 mem_rd addr 00; T2 pc=01; T4 reg_we=1, rd_sel=3, wb_sel=1.
//   - SUB r1,r2 with alu_z=1, then JZ 40 -> pc=40 after JZ's T3; same with alu_z=0 -> pc continues +1.
//   - JMP FF at FE, then NOP at FF -> pc=FF after the JMP, then wraps to 00 after the NOP's T2.
//   - HALT -> halted=1 from that T3 edge; 3 further beat rounds: pc/ir unchanged, all strobes 0.
//   - t forced 0011 for one cycle -> beat_err=1 sticky, no pc/ir change; opcode D -> illegal_op pulse in T2.

Source files
------------

// File: rtl/cpu_defs_pkg.sv
// Shared definitions for the multicycle CPU control path.
//   - opcode values carried in ir[15:12]
//   - one-hot beat constants T1..T4 produced by the four-beat generator
//   - ALU operation codes and register-file write-back select codes
//   - op_class_t: coarse instruction class used by the control unit
package cpu_defs_pkg;

    localparam logic [3:0] OP_NOP  = 4'h0;
    localparam logic [3:0] OP_ADD  = 4'h1;
    localparam logic [3:0] OP_SUB  = 4'h2;
    localparam logic [3:0] OP_AND  = 4'h3;
    localparam logic [3:0] OP_OR   = 4'h4;
    localparam logic [3:0] OP_XOR  = 4'h5;
    localparam logic [3:0] OP_MOV  = 4'h6;
    localparam logic [3:0] OP_MVI  = 4'h7;
    localparam logic [3:0] OP_LDA  = 4'h8;
    localparam logic [3:0] OP_STA  = 4'h9;
    localparam logic [3:0] OP_JMP  = 4'hA;
    localparam logic [3:0] OP_JZ   = 4'hB;
    localparam logic [3:0] OP_JC   = 4'hC;
    localparam logic [3:0] OP_ILLD = 4'hD;
    localparam logic [3:0] OP_ILLE = 4'hE;
    localparam logic [3:0] OP_HALT = 4'hF;

    localparam logic [3:0] T1 = 4'b0001;
    localparam logic [3:0] T2 = 4'b0010;
    localparam logic [3:0] T3 = 4'b0100;
    localparam logic [3:0] T4 = 4'b1000;

    localparam logic [2:0] ALU_ADD    = 3'd0;
    localparam logic [2:0] ALU_SUB    = 3'd1;
    localparam logic [2:0] ALU_AND    = 3'd2;
    localparam logic [2:0] ALU_OR     = 3'd3;
    localparam logic [2:0] ALU_XOR    = 3'd4;
    localparam logic [2:0] ALU_PASS_B = 3'd5;

    localparam logic [1:0] WB_ALU = 2'd0;
    localparam logic [1:0] WB_IMM = 2'd1;
    localparam logic [1:0] WB_MEM = 2'd2;

    typedef enum logic [3:0] {
        CLS_NONE,
        CLS_ALU,
        CLS_MOV,
        CLS_MVI,
        CLS_LDA,
        CLS_STA,
        CLS_JMP,
        CLS_JZ,
        CLS_JC,
        CLS_HALT
    } op_class_t;

endpackage

// File: rtl/instr_decoder.sv
// Purely combinational opcode decoder.
// Ports:
//   i_opcode   in   4   ir[15:12]
//   o_cls      out  op_class_t  instruction class
//   o_alu_op   out  3   ALU operation for ALU ops and MOV (ADD otherwise)
//   o_wb_sel   out  2   write-back source for register-writing classes
//   o_illegal  out  1   opcode D or E (executed as NOP)
module instr_decoder
    import cpu_defs_pkg::*;
(
    input  logic [3:0] i_opcode,
    output op_class_t  o_cls,
    output logic [2:0] o_alu_op,
    output logic [1:0] o_wb_sel,
    output logic       o_illegal
);

    always_comb begin
        o_cls     = CLS_NONE;
        o_alu_op  = ALU_ADD;
        o_wb_sel  = WB_ALU;
        o_illegal = 1'b0;
        case (i_opcode)
            OP_ADD:  begin o_cls = CLS_ALU; o_alu_op = ALU_ADD; end
            OP_SUB:  begin o_cls = CLS_ALU; o_alu_op = ALU_SUB; end
            OP_AND:  begin o_cls = CLS_ALU; o_alu_op = ALU_AND; end
            OP_OR:   begin o_cls = CLS_ALU; o_alu_op = ALU_OR;  end
            OP_XOR:  begin o_cls = CLS_ALU; o_alu_op = ALU_XOR; end
            OP_MOV:  begin o_cls = CLS_MOV; o_alu_op = ALU_PASS_B; end
            OP_MVI:  begin o_cls = CLS_MVI; o_wb_sel = WB_IMM; end
            OP_LDA:  begin o_cls = CLS_LDA; o_wb_sel = WB_MEM; end
            OP_STA:  o_cls = CLS_STA;
            OP_JMP:  o_cls = CLS_JMP;
            OP_JZ:   o_cls = CLS_JZ;
            OP_JC:   o_cls = CLS_JC;
            OP_HALT: o_cls = CLS_HALT;
            OP_ILLD, OP_ILLE: o_illegal = 1'b1;
            default: o_cls = CLS_NONE;
        endcase
    end

endmodule

// File: rtl/beat_control_unit.sv
// Hardwired control unit for the multicycle CPU. One instruction per beat
// round: T1 fetch, T2 decode/PC++, T3 execute, T4 write-back.
// Ports:
//   clk, rst          clock; asynchronous active-high reset
//   t[3:0]            one-hot beat from the beat generator (0000 = idle)
//   instr_in          instruction word from memory, sampled in T1
//   alu_z, alu_c      ALU flags, sampled in T3 of ALU ops
//   pc, ir            program counter, instruction register
//   mem_addr/rd/wr    memory address and strobes
//   alu_op, alu_en    ALU operation and latch enable
//   rd_sel, rs_sel    register selects ir[10:8], ir[2:0]
//   wb_sel, reg_we    write-back source and register-file write enable
//   halted            sticky after HALT
//   illegal_op        one-cycle pulse in T2 for opcode D/E
//   beat_err          sticky: malformed beat vector seen
module beat_control_unit
    import cpu_defs_pkg::*;
#(
    parameter int              PC_W     = 8,
    parameter int              IR_W     = 16,
    parameter logic [PC_W-1:0] RESET_PC = 8'h00
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [3:0]      t,
    input  logic [IR_W-1:0] instr_in,
    input  logic            alu_z,
    input  logic            alu_c,
    output logic [PC_W-1:0] pc,
    output logic [IR_W-1:0] ir,
    output logic [PC_W-1:0] mem_addr,
    output logic            mem_rd,
    output logic            mem_wr,
    output logic [2:0]      alu_op,
    output logic            alu_en,
    output logic [2:0]      rd_sel,
    output logic [2:0]      rs_sel,
    output logic [1:0]      wb_sel,
    output logic            reg_we,
    output logic            halted,
    output logic            illegal_op,
    output logic            beat_err
);

    logic [PC_W-1:0] r_pc;
    logic [IR_W-1:0] r_ir;
    logic            r_halted;
    logic            r_z;
    logic            r_c;
    logic            r_beat_err;

    op_class_t       w_cls;
    logic [2:0]      w_alu_op;
    logic [1:0]      w_wb_sel;
    logic            w_illegal;
    logic            w_onehot;
    logic [PC_W-1:0] w_target;

    instr_decoder u_dec (
        .i_opcode  (r_ir[IR_W-1 -: 4]),
        .o_cls     (w_cls),
        .o_alu_op  (w_alu_op),
        .o_wb_sel  (w_wb_sel),
        .o_illegal (w_illegal)
    );

    assign w_onehot = (t == T1) || (t == T2) || (t == T3) || (t == T4);
    assign w_target = r_ir[PC_W-1:0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pc       <= RESET_PC;
            r_ir       <= '0;
            r_halted   <= 1'b0;
            r_z        <= 1'b0;
            r_c        <= 1'b0;
            r_beat_err <= 1'b0;
        end else begin
            if ((t != 4'b0000) && !w_onehot)
                r_beat_err <= 1'b1;
            // Non-one-hot and zero beats fall through every item: idle.
            if (!r_halted) begin
                case (t)
                    T1: r_ir <= instr_in;
                    T2: r_pc <= r_pc + PC_W'(1);
                    T3: begin
                        case (w_cls)
                            CLS_ALU: begin
                                r_z <= alu_z;
                                r_c <= alu_c;
                            end
                            CLS_JMP:  r_pc <= w_target;
                            CLS_JZ:   if (r_z) r_pc <= w_target;
                            CLS_JC:   if (r_c) r_pc <= w_target;
                            CLS_HALT: r_halted <= 1'b1;
                            default:  ;
                        endcase
                    end
                    default: ;
                endcase
            end
        end
    end

    // Strobes are gated by rst as well as halted: during reset the beat
    // generator may still present a beat, and a T1 would otherwise fetch.
    always_comb begin
        mem_addr   = '0;
        mem_rd     = 1'b0;
        mem_wr     = 1'b0;
        alu_en     = 1'b0;
        alu_op     = ALU_ADD;
        reg_we     = 1'b0;
        wb_sel     = WB_ALU;
        illegal_op = 1'b0;
        if (!rst && !r_halted) begin
            case (t)
                T1: begin
                    mem_addr = r_pc;
                    mem_rd   = 1'b1;
                end
                T2: illegal_op = w_illegal;
                T3: begin
                    case (w_cls)
                        CLS_ALU, CLS_MOV: begin
                            alu_en = 1'b1;
                            alu_op = w_alu_op;
                        end
                        CLS_LDA: begin
                            mem_addr = w_target;
                            mem_rd   = 1'b1;
                        end
                        CLS_STA: begin
                            mem_addr = w_target;
                            mem_wr   = 1'b1;
                        end
                        default: ;
                    endcase
                end
                T4: begin
                    if (w_cls == CLS_ALU || w_cls == CLS_MOV ||
                        w_cls == CLS_MVI || w_cls == CLS_LDA) begin
                        reg_we = 1'b1;
                        wb_sel = w_wb_sel;
                    end
                end
                default: ;
            endcase
        end
    end

    assign pc       = r_pc;
    assign ir       = r_ir;
    assign rd_sel   = r_ir[10:8];
    assign rs_sel   = r_ir[2:0];
    assign halted   = r_halted;
    assign beat_err = r_beat_err;

endmodule

// File: tb/tb_beat_control_unit.sv
// Bench for beat_control_unit. Each driven cycle pushes the hand-computed
// output snapshot for that cycle; a monitor on the falling edge pops and
// compares it with what the DUT presents.
module tb_beat_control_unit;

    localparam int EW = 8 + 16 + 8 + 7 + 3 + 2 + 3 + 3;

    // flag bits: {mem_rd, mem_wr, alu_en, reg_we, halted, illegal_op, beat_err}
    localparam logic [6:0] RD = 7'h40;
    localparam logic [6:0] WR = 7'h20;
    localparam logic [6:0] AE = 7'h10;
    localparam logic [6:0] WE = 7'h08;
    localparam logic [6:0] HL = 7'h04;
    localparam logic [6:0] IL = 7'h02;
    localparam logic [6:0] BE = 7'h01;
    localparam logic [6:0] NO = 7'h00;

    localparam logic [3:0] B1 = 4'b0001;
    localparam logic [3:0] B2 = 4'b0010;
    localparam logic [3:0] B3 = 4'b0100;
    localparam logic [3:0] B4 = 4'b1000;
    localparam logic [3:0] B0 = 4'b0000;

    logic        clk;
    logic        rst;
    logic [3:0]  t;
    logic [15:0] instr_in;
    logic        alu_z;
    logic        alu_c;
    logic [7:0]  pc;
    logic [15:0] ir;
    logic [7:0]  mem_addr;
    logic        mem_rd;
    logic        mem_wr;
    logic [2:0]  alu_op;
    logic        alu_en;
    logic [2:0]  rd_sel;
    logic [2:0]  rs_sel;
    logic [1:0]  wb_sel;
    logic        reg_we;
    logic        halted;
    logic        illegal_op;
    logic        beat_err;

    logic [EW-1:0] exp_q[$];
    string         name_q[$];
    int            n_cmp;
    int            n_err;

    beat_control_unit dut (
        .clk        (clk),
        .rst        (rst),
        .t          (t),
        .instr_in   (instr_in),
        .alu_z      (alu_z),
        .alu_c      (alu_c),
        .pc         (pc),
        .ir         (ir),
        .mem_addr   (mem_addr),
        .mem_rd     (mem_rd),
        .mem_wr     (mem_wr),
        .alu_op     (alu_op),
        .alu_en     (alu_en),
        .rd_sel     (rd_sel),
        .rs_sel     (rs_sel),
        .wb_sel     (wb_sel),
        .reg_we     (reg_we),
        .halted     (halted),
        .illegal_op (illegal_op),
        .beat_err   (beat_err)
    );

    // clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // driver: one call = one clock cycle of inputs plus its expected outputs
    task automatic cyc(input string nm, input logic rr, input logic [3:0] tt,
                       input logic [15:0] ins, input logic z, input logic c,
                       input logic [7:0] e_pc, input logic [15:0] e_ir,
                       input logic [7:0] e_addr, input logic [6:0] e_fl,
                       input logic [2:0] e_aop, input logic [1:0] e_wb);
        @(posedge clk);
        #1;
        rst      = rr;
        t        = tt;
        instr_in = ins;
        alu_z    = z;
        alu_c    = c;
        exp_q.push_back({e_pc, e_ir, e_addr, e_fl, e_aop, e_wb, e_ir[10:8], e_ir[2:0]});
        name_q.push_back(nm);
    endtask

    // monitor / scoreboard
    initial begin
        logic [EW-1:0] act;
        logic [EW-1:0] exp_v;
        string         nm;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                exp_v = exp_q.pop_front();
                nm    = name_q.pop_front();
                act   = {pc, ir, mem_addr,
                         {mem_rd, mem_wr, alu_en, reg_we, halted, illegal_op, beat_err},
                         alu_op, wb_sel, rd_sel, rs_sel};
                n_cmp++;
                if (act !== exp_v) begin
                    n_err++;
                    $display("FAIL %s: got pc=%h ir=%h addr=%h fl=%b aop=%0d wb=%0d rd=%0d rs=%0d, need pc=%h ir=%h addr=%h fl=%b aop=%0d wb=%0d rd=%0d rs=%0d",
                             nm, act[49:42], act[41:26], act[25:18], act[17:11], act[10:8], act[7:6], act[5:3], act[2:0],
                             exp_v[49:42], exp_v[41:26], exp_v[25:18], exp_v[17:11], exp_v[10:8], exp_v[7:6], exp_v[5:3], exp_v[2:0]);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // stimulus
    initial begin
        n_cmp    = 0;
        n_err    = 0;
        rst      = 1'b1;
        t        = B0;
        instr_in = '0;
        alu_z    = 1'b0;
        alu_c    = 1'b0;

        //   name           rst t   instr    z  c  pc     ir       addr   flags      aop  wb
        cyc("reset_t1",     1, B1, 16'h1111, 0, 0, 8'h00, 16'h0000, 8'h00, NO,      0, 0);
        cyc("idle",         0, B0, 16'h2222, 0, 0, 8'h00, 16'h0000, 8'h00, NO,      0, 0);
        // 00: MVI r3,#5A
        cyc("mvi_t1",       0, B1, 16'h735A, 0, 0, 8'h00, 16'h0000, 8'h00, RD,      0, 0);
        cyc("mvi_t2",       0, B2, 16'h0000, 0, 0, 8'h00, 16'h735A, 8'h00, NO,      0, 0);
        cyc("mvi_t3",       0, B3, 16'h0000, 0, 0, 8'h01, 16'h735A, 8'h00, NO,      0, 0);
        cyc("mvi_t4",       0, B4, 16'h0000, 0, 0, 8'h01, 16'h735A, 8'h00, WE,      0, 1);
        // 01: SUB r1,r2 with z=1
        cyc("sub_t1",       0, B1, 16'h2102, 0, 0, 8'h01, 16'h735A, 8'h01, RD,      0, 0);
        cyc("sub_t2",       0, B2, 16'h0000, 0, 0, 8'h01, 16'h2102, 8'h00, NO,      0, 0);
        cyc("sub_t3",       0, B3, 16'h0000, 1, 0, 8'h02, 16'h2102, 8'h00, AE,      1, 0);
        cyc("sub_t4",       0, B4, 16'h0000, 0, 0, 8'h02, 16'h2102, 8'h00, WE,      0, 0);
        // 02: JZ 40, taken
        cyc("jz_t1",        0, B1, 16'hB040, 0, 0, 8'h02, 16'h2102, 8'h02, RD,      0, 0);
        cyc("jz_t2",        0, B2, 16'h0000, 0, 0, 8'h02, 16'hB040, 8'h00, NO,      0, 0);
        cyc("jz_t3",        0, B3, 16'h0000, 0, 0, 8'h03, 16'hB040, 8'h00, NO,      0, 0);
        cyc("jz_taken",     0, B4, 16'h0000, 0, 0, 8'h40, 16'hB040, 8'h00, NO,      0, 0);
        // 40: SUB with z=0, c=1
        cyc("sub2_t1",      0, B1, 16'h2102, 0, 0, 8'h40, 16'hB040, 8'h40, RD,      0, 0);
        cyc("sub2_t2",      0, B2, 16'h0000, 0, 0, 8'h40, 16'h2102, 8'h00, NO,      0, 0);
        cyc("sub2_t3",      0, B3, 16'h0000, 0, 1, 8'h41, 16'h2102, 8'h00, AE,      1, 0);
        cyc("sub2_t4",      0, B4, 16'h0000, 0, 0, 8'h41, 16'h2102, 8'h00, WE,      0, 0);
        // 41: JZ 40, not taken
        cyc("jz2_t1",       0, B1, 16'hB040, 0, 0, 8'h41, 16'h2102, 8'h41, RD,      0, 0);
        cyc("jz2_t2",       0, B2, 16'h0000, 0, 0, 8'h41, 16'hB040, 8'h00, NO,      0, 0);
        cyc("jz2_t3",       0, B3, 16'h0000, 0, 0, 8'h42, 16'hB040, 8'h00, NO,      0, 0);
        cyc("jz_not_taken", 0, B4, 16'h0000, 0, 0, 8'h42, 16'hB040, 8'h00, NO,      0, 0);
        // 42: STA r5,[80], reset during its T3
        cyc("sta_t1",       0, B1, 16'h9580, 0, 0, 8'h42, 16'hB040, 8'h42, RD,      0, 0);
        cyc("sta_t2",       0, B2, 16'h0000, 0, 0, 8'h42, 16'h9580, 8'h00, NO,      0, 0);
        cyc("sta_t3",       0, B3, 16'h0000, 0, 0, 8'h43, 16'h9580, 8'h80, WR,      0, 0);
        cyc("sta_rst",      1, B3, 16'h0000, 0, 0, 8'h00, 16'h0000, 8'h00, NO,      0, 0);
        cyc("post_rst",     0, B0, 16'h0000, 0, 0, 8'h00, 16'h0000, 8'h00, NO,      0, 0);
        // 00: JMP FE
        cyc("jmp_fetch00",  0, B1, 16'hA0FE, 0, 0, 8'h00, 16'h0000, 8'h00, RD,      0, 0);
        cyc("jmp_t2",       0, B2, 16'h0000, 0, 0, 8'h00, 16'hA0FE, 8'h00, NO,      0, 0);
        cyc("jmp_t3",       0, B3, 16'h0000, 0, 0, 8'h01, 16'hA0FE, 8'h00, NO,      0, 0);
        cyc("jmp_t4",       0, B4, 16'h0000, 0, 0, 8'hFE, 16'hA0FE, 8'h00, NO,      0, 0);
        // FE: JMP FF
        cyc("jmpff_t1",     0, B1, 16'hA0FF, 0, 0, 8'hFE, 16'hA0FE, 8'hFE, RD,      0, 0);
        cyc("jmpff_t2",     0, B2, 16'h0000, 0, 0, 8'hFE, 16'hA0FF, 8'h00, NO,      0, 0);
        cyc("jmpff_t3",     0, B3, 16'h0000, 0, 0, 8'hFF, 16'hA0FF, 8'h00, NO,      0, 0);
        cyc("jmpff_t4",     0, B4, 16'h0000, 0, 0, 8'hFF, 16'hA0FF, 8'h00, NO,      0, 0);
        // FF: NOP, pc wraps to 00
        cyc("nop_t1",       0, B1, 16'h0000, 0, 0, 8'hFF, 16'hA0FF, 8'hFF, RD,      0, 0);
        cyc("nop_t2",       0, B2, 16'h0000, 0, 0, 8'hFF, 16'h0000, 8'h00, NO,      0, 0);
        cyc("pc_wrap",      0, B3, 16'h0000, 0, 0, 8'h00, 16'h0000, 8'h00, NO,      0, 0);
        cyc("nop_t4",       0, B4, 16'h0000, 0, 0, 8'h00, 16'h0000, 8'h00, NO,      0, 0);
        // 00: opcode D
        cyc("ill_t1",       0, B1, 16'hD000, 0, 0, 8'h00, 16'h0000, 8'h00, RD,      0, 0);
        cyc("ill_pulse",    0, B2, 16'h0000, 0, 0, 8'h00, 16'hD000, 8'h00, IL,      0, 0);
        cyc("ill_t3",       0, B3, 16'h0000, 1, 1, 8'h01, 16'hD000, 8'h00, NO,      0, 0);
        cyc("ill_t4",       0, B4, 16'h0000, 0, 0, 8'h01, 16'hD000, 8'h00, NO,      0, 0);
        // malformed beat
        cyc("bad_beat",     0, 4'b0011, 16'hFFFF, 0, 0, 8'h01, 16'hD000, 8'h00, NO, 0, 0);
        cyc("beat_err",     0, B0, 16'hFFFF, 0, 0, 8'h01, 16'hD000, 8'h00, BE,      0, 0);
        // 01: ADD with c=1
        cyc("add_t1",       0, B1, 16'h1102, 0, 0, 8'h01, 16'hD000, 8'h01, RD|BE,   0, 0);
        cyc("add_t2",       0, B2, 16'h0000, 0, 0, 8'h01, 16'h1102, 8'h00, BE,      0, 0);
        cyc("add_t3",       0, B3, 16'h0000, 0, 1, 8'h02, 16'h1102, 8'h00, AE|BE,   0, 0);
        cyc("add_t4",       0, B4, 16'h0000, 0, 0, 8'h02, 16'h1102, 8'h00, WE|BE,   0, 0);
        // 02: JC 20, taken
        cyc("jc_t1",        0, B1, 16'hC020, 0, 0, 8'h02, 16'h1102, 8'h02, RD|BE,   0, 0);
        cyc("jc_t2",        0, B2, 16'h0000, 0, 0, 8'h02, 16'hC020, 8'h00, BE,      0, 0);
        cyc("jc_t3",        0, B3, 16'h0000, 0, 0, 8'h03, 16'hC020, 8'h00, BE,      0, 0);
        cyc("jc_taken",     0, B4, 16'h0000, 0, 0, 8'h20, 16'hC020, 8'h00, BE,      0, 0);
        // 20: LDA r2,[33]
        cyc("lda_t1",       0, B1, 16'h8233, 0, 0, 8'h20, 16'hC020, 8'h20, RD|BE,   0, 0);
        cyc("lda_t2",       0, B2, 16'h0000, 0, 0, 8'h20, 16'h8233, 8'h00, BE,      0, 0);
        cyc("lda_t3",       0, B3, 16'h0000, 0, 0, 8'h21, 16'h8233, 8'h33, RD|BE,   0, 0);
        cyc("lda_t4",       0, B4, 16'h0000, 0, 0, 8'h21, 16'h8233, 8'h00, WE|BE,   0, 2);
        // 21: HALT
        cyc("halt_t1",      0, B1, 16'hF000, 0, 0, 8'h21, 16'h8233, 8'h21, RD|BE,   0, 0);
        cyc("halt_t2",      0, B2, 16'h0000, 0, 0, 8'h21, 16'hF000, 8'h00, BE,      0, 0);
        cyc("halt_t3",      0, B3, 16'h0000, 0, 0, 8'h22, 16'hF000, 8'h00, BE,      0, 0);
        cyc("halted",       0, B4, 16'h0000, 0, 0, 8'h22, 16'hF000, 8'h00, HL|BE,   0, 0);
        for (int r = 0; r < 3; r++) begin
            cyc("halt_r_t1", 0, B1, 16'h1234, 1, 1, 8'h22, 16'hF000, 8'h00, HL|BE,  0, 0);
            cyc("halt_r_t2", 0, B2, 16'hA055, 1, 1, 8'h22, 16'hF000, 8'h00, HL|BE,  0, 0);
            cyc("halt_r_t3", 0, B3, 16'h0000, 1, 1, 8'h22, 16'hF000, 8'h00, HL|BE,  0, 0);
            cyc("halt_r_t4", 0, B4, 16'h0000, 1, 1, 8'h22, 16'hF000, 8'h00, HL|BE,  0, 0);
        end

        // let the monitor drain the queue, bounded
        for (int k = 0; k < 20 && exp_q.size() > 0; k++) @(posedge clk);
        if (exp_q.size() > 0) begin
            n_err++;
            $display("FAIL drain: %0d entries left, need 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
